macc_cplx_nch: RTL and testbench
================================

# macc_cplx_nch

Multi-channel complex multiply-accumulate engine for the CRPA datapath. It computes NCH parallel complex products a·b or a·conj(b) per accepted sample and integrates them over a programmable number of samples. It dumps the saturated sums with a one-cycle valid strobe and restarts integration with no dead cycles. It is the generalised successor to the scalar real MAC: complex, multi-channel, with valid-qualified input, self-timed dumping, a conjugate mode and saturation.

## Interface
- SIZEIN, 16: width of each signed real/imag input component.
- SIZEACC, 40: width of each signed real/imag accumulator; must be ≥ 2*SIZEIN+1.
- NCH, 4: number of independent channels; must be ≥ 1.
- LENW, 16: width of acc_len.

- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset; synchronous, active-high.
- clr  in  1  synchronous flush: aborts the current integration period.
- in_valid  in  1  qualifies a_*/b_*/conj_b this cycle.
- a_re, a_im  in  NCH*SIZEIN  signed; channel k at bits [k*SIZEIN +: SIZEIN].
- b_re, b_im  in  NCH*SIZEIN  signed; same packing.
- conj_b  in  1  1 = multiply by conj(b); travels with its sample.
- acc_len  in  LENW  samples per integration period; 0 treated as 1.
- out_valid  out  1  one-cycle dump strobe.
- out_re, out_im  out  NCH*SIZEACC  signed dumped sums; same packing; held between dumps.
- ovf  out  NCH  per-channel saturation flag for the dumped period; valid with out_valid, held.

## Operation
- Three-stage pipeline, each stage with its own valid bit:
  - S1: register inputs and conj_b when in_valid.
  - S2: complex multiply, per channel, at full width 2*SIZEIN+1.
    - Normal: re = ar·br − ai·bi, im = ai·br + ar·bi.
    - Conjugate: re = ar·br + ai·bi, im = ai·br − ar·bi.
  - S3: sign-extend the product to SIZEACC and add it to the running accumulator.
- Gaps in in_valid stall nothing; bubbles pass through without touching the accumulators or the counter.
- Sample counter cnt (LENW bits) advances only on an S3-valid sample.
- Period length L = max(acc_len, 1) is latched when the first sample of a period reaches S3. Changing acc_len mid-period has no effect until the next period.
- When an S3-valid sample has cnt == L−1:
  - out_re/out_im ← saturated (accumulator + product).
  - ovf ← per-channel sticky flag OR'ed with this final add's overflow.
  - out_valid = 1 for one cycle.
  - accumulator, sticky flags and cnt reset to 0.
  - The next S3-valid sample starts a new period immediately.
- Saturation: an add whose true result exceeds 2^(SIZEACC−1)−1 clamps to that value; below −2^(SIZEACC−1) clamps to −2^(SIZEACC−1). Either case sets that channel's sticky flag. Real and imag parts clamp independently; a channel's flag is the OR of both.
- clr: at the next edge the accumulators, cnt, sticky flags and all pipeline valid bits clear.
  - Samples in flight are discarded and out_valid is not asserted for the aborted period.
  - out_re/out_im/ovf keep their last dumped values.
  - An in_valid sample presented in the same cycle as clr is also discarded.
- rst: same as clr, and additionally out_re = 0, out_im = 0, ovf = 0, out_valid = 0.

## Timing
- Latency: sample with in_valid sampled at edge t → enters S3 at edge t+2. If it is the last sample, out_valid is high in the cycle after edge t+2, i.e. 3 cycles after its in_valid cycle.
- Throughput: one sample per clock per channel. With acc_len = 1 and continuous in_valid, out_valid is high every cycle.
- Reset values: out_valid 0, out_re 0, out_im 0, ovf 0, cnt 0, accumulators 0, stage valids 0.
- rst has priority over clr; clr has priority over a dump in the same cycle, so no strobe is issued.
- cnt never wraps: L ≤ 2^LENW−1, and the terminal count always dumps.

## Test plan
- NCH=2, SIZEIN=8, SIZEACC=24, acc_len=4, conj_b=0, a=3+4j, b=1+2j on both channels, 4 valid cycles → one out_valid 3 cycles after the 4th sample; out = −20+40j on both channels; ovf=00.
- Same stimulus with conj_b=1 → out = 44−8j; conj_b toggled per sample (0,1,0,1) → out = 2·(−5+10j) + 2·(11−2j) = 12+16j.
- SIZEACC=17, acc_len=5, a=127, b=127 (imag 0) → the 5th add (true 80645) clamps out_re to 65535; ovf=1 for that channel only; the next period starts from 0 with ovf cleared.
- acc_len=1, continuous in_valid with a=k, b=1 (k = 1, 2, 3, …) → out_valid every cycle after 3-cycle latency; out_re = k in sequence.
- acc_len=3, in_valid pattern 1,0,0,1,0,1 → single dump equal to the sum of the 3 valid products, 3 cycles after the last valid.
- acc_len=4; clr after 2 samples, then 4 more samples → no strobe for the aborted period; the next dump contains only the 4 post-clr samples. rst mid-period → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/macc_cplx_nch_if.sv
// macc_cplx_nch_if: sample input and dump output bundle of the complex MAC engine.
interface macc_cplx_nch_if #(
  parameter int SIZEIN  = 16,
  parameter int SIZEACC = 40,
  parameter int NCH     = 4,
  parameter int LENW    = 16
) ();
  logic                   clr;
  logic                   in_valid;
  logic [NCH*SIZEIN-1:0]  a_re, a_im, b_re, b_im;
  logic                   conj_b;
  logic [LENW-1:0]        acc_len;
  logic                   out_valid;
  logic [NCH*SIZEACC-1:0] out_re, out_im;
  logic [NCH-1:0]         ovf;
  modport master (
    output clr, in_valid, a_re, a_im, b_re, b_im, conj_b, acc_len,
    input  out_valid, out_re, out_im, ovf
  );
  modport slave (
    input  clr, in_valid, a_re, a_im, b_re, b_im, conj_b, acc_len,
    output out_valid, out_re, out_im, ovf
  );
endinterface

// File: rtl/macc_cplx_nch.sv
// macc_cplx_nch: multi-channel complex multiply-accumulate with saturating self-timed dumps.
module macc_cplx_nch #(
  parameter int SIZEIN  = 16,
  parameter int SIZEACC = 40,
  parameter int NCH     = 4,
  parameter int LENW    = 16
) (
  input logic           clk,
  input logic           rst,
  macc_cplx_nch_if.slave bus
);
  localparam int P = 2*SIZEIN+1;
  logic                  v1, v2, cj1, last;
  logic [NCH*SIZEIN-1:0] ar1, ai1, br1, bi1;
  logic [P-1:0]          pr[NCH], pi[NCH], pr2[NCH], pi2[NCH];
  logic [SIZEACC-1:0]    acc_re[NCH], acc_im[NCH], sat_re[NCH], sat_im[NCH];
  logic [NCH-1:0]        sticky, f;
  logic [LENW-1:0]       cnt, len_q, cur_len;
  for (genvar g = 0; g < NCH; g++) begin : ch
    logic signed [SIZEIN-1:0]   ar, ai, br, bi;
    logic signed [2*SIZEIN-1:0] rr, ii, ir, ri;
    logic [SIZEACC:0]           sr, si;
    assign ar = ar1[g*SIZEIN +: SIZEIN];
    assign ai = ai1[g*SIZEIN +: SIZEIN];
    assign br = br1[g*SIZEIN +: SIZEIN];
    assign bi = bi1[g*SIZEIN +: SIZEIN];
    assign rr = ar * br;
    assign ii = ai * bi;
    assign ir = ai * br;
    assign ri = ar * bi;
    assign pr[g] = cj1 ? {rr[2*SIZEIN-1], rr} + {ii[2*SIZEIN-1], ii} : {rr[2*SIZEIN-1], rr} - {ii[2*SIZEIN-1], ii};
    assign pi[g] = cj1 ? {ir[2*SIZEIN-1], ir} - {ri[2*SIZEIN-1], ri} : {ir[2*SIZEIN-1], ir} + {ri[2*SIZEIN-1], ri};
    // one guard bit above the accumulator exposes overflow as a sign mismatch
    assign sr = {acc_re[g][SIZEACC-1], acc_re[g]} + {{(SIZEACC+1-P){pr2[g][P-1]}}, pr2[g]};
    assign si = {acc_im[g][SIZEACC-1], acc_im[g]} + {{(SIZEACC+1-P){pi2[g][P-1]}}, pi2[g]};
    assign sat_re[g] = (sr[SIZEACC] == sr[SIZEACC-1]) ? sr[SIZEACC-1:0] : {sr[SIZEACC], {(SIZEACC-1){~sr[SIZEACC]}}};
    assign sat_im[g] = (si[SIZEACC] == si[SIZEACC-1]) ? si[SIZEACC-1:0] : {si[SIZEACC], {(SIZEACC-1){~si[SIZEACC]}}};
    assign f[g] = (sr[SIZEACC] ^ sr[SIZEACC-1]) | (si[SIZEACC] ^ si[SIZEACC-1]);
  end
  // the period length is taken live for the first sample, then held
  assign cur_len = (cnt == '0) ? ((bus.acc_len == '0) ? LENW'(1) : bus.acc_len) : len_q;
  assign last = v2 && (cnt == cur_len - LENW'(1));
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= bus.in_valid;
      v2 <= v1;
      if (bus.in_valid) begin
        ar1 <= bus.a_re;
        ai1 <= bus.a_im;
        br1 <= bus.b_re;
        bi1 <= bus.b_im;
        cj1 <= bus.conj_b;
      end
      if (v1)
        for (int k = 0; k < NCH; k++) begin
          pr2[k] <= pr[k];
          pi2[k] <= pi[k];
        end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      len_q         <= '0;
      sticky        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_re    <= '0;
      bus.out_im    <= '0;
      bus.ovf       <= '0;
      for (int k = 0; k < NCH; k++) begin
        acc_re[k] <= '0;
        acc_im[k] <= '0;
      end
    end else if (bus.clr) begin
      cnt           <= '0;
      sticky        <= '0;
      bus.out_valid <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        acc_re[k] <= '0;
        acc_im[k] <= '0;
      end
    end else begin
      bus.out_valid <= last;
      if (v2) begin
        if (cnt == '0) len_q <= cur_len;
        if (last) begin
          bus.ovf <= sticky | f;
          sticky  <= '0;
          cnt     <= '0;
          for (int k = 0; k < NCH; k++) begin
            bus.out_re[k*SIZEACC +: SIZEACC] <= sat_re[k];
            bus.out_im[k*SIZEACC +: SIZEACC] <= sat_im[k];
            acc_re[k] <= '0;
            acc_im[k] <= '0;
          end
        end else begin
          sticky <= sticky | f;
          cnt    <= cnt + LENW'(1);
          for (int k = 0; k < NCH; k++) begin
            acc_re[k] <= sat_re[k];
            acc_im[k] <= sat_im[k];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_macc_cplx_nch.sv
// tb_macc_cplx_nch: directed vectors for a 2-channel, 8-bit input, 17-bit accumulator instance.
module tb_macc_cplx_nch;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  macc_cplx_nch_if #(.SIZEIN(8), .SIZEACC(17), .NCH(2), .LENW(8)) bus ();
  macc_cplx_nch #(.SIZEIN(8), .SIZEACC(17), .NCH(2), .LENW(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [33:0] two(input int c1, input int c0);
    return {17'(c1), 17'(c0)};
  endfunction
  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [15:0] ar, ai, br, bi, input logic cj);
    bus.in_valid = v;
    bus.a_re     = ar;
    bus.a_im     = ai;
    bus.b_re     = br;
    bus.b_im     = bi;
    bus.conj_b   = cj;
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
  endtask
  // four samples of a=3+4j, b=1+2j with a per-sample conjugate pattern, then the dump
  task automatic period4(input string tag, input logic [3:0] cj, input int re, input int im);
    for (int i = 0; i < 4; i++) drive(1'b1, 16'h0303, 16'h0404, 16'h0101, 16'h0202, cj[i]);
    idle();
    chk({tag, "_early"}, 34'(bus.out_valid), 34'(0));
    idle();
    chk({tag, "_valid"}, 34'(bus.out_valid), 34'(1));
    chk({tag, "_re"}, bus.out_re, two(re, re));
    chk({tag, "_im"}, bus.out_im, two(im, im));
    chk({tag, "_ovf"}, 34'(bus.ovf), 34'(0));
    idle();
    chk({tag, "_strobe1"}, 34'(bus.out_valid), 34'(0));
    chk({tag, "_hold"}, bus.out_re, two(re, re));
  endtask
  initial begin
    rst = 1'b1;
    bus.clr = 1'b0;
    bus.acc_len = 8'd4;
    idle();
    idle();
    rst = 1'b0;
    chk("rst_valid", 34'(bus.out_valid), 34'(0));
    chk("rst_re", bus.out_re, 34'(0));
    chk("rst_im", bus.out_im, 34'(0));
    chk("rst_ovf", 34'(bus.ovf), 34'(0));
    period4("normal", 4'b0000, -20, 40);
    period4("conj", 4'b1111, 44, -8);
    period4("toggle", 4'b1010, 12, 16);
    // ch0 saturates on the 5th add (80645 > 65535); ch1 stays small
    bus.acc_len = 8'd5;
    for (int i = 0; i < 5; i++) drive(1'b1, 16'h017f, 16'h0, 16'h017f, 16'h0, 1'b0);
    idle();
    idle();
    chk("sat_valid", 34'(bus.out_valid), 34'(1));
    chk("sat_re", bus.out_re, two(5, 65535));
    chk("sat_im", bus.out_im, 34'(0));
    chk("sat_ovf", 34'(bus.ovf), 34'(1));
    for (int i = 0; i < 5; i++) drive(1'b1, 16'h0101, 16'h0, 16'h0101, 16'h0, 1'b0);
    idle();
    chk("sat_held_ovf", 34'(bus.ovf), 34'(1));
    idle();
    chk("next_re", bus.out_re, two(5, 5));
    chk("next_ovf", 34'(bus.ovf), 34'(0));
    bus.acc_len = 8'd1;
    for (int k = 1; k <= 8; k++) begin
      if (k <= 6) drive(1'b1, {8'(k), 8'(k)}, 16'h0, 16'h0101, 16'h0, 1'b0);
      else idle();
      if (k >= 3) begin
        chk($sformatf("len1_valid%0d", k), 34'(bus.out_valid), 34'(1));
        chk($sformatf("len1_re%0d", k), bus.out_re, two(k-2, k-2));
      end
    end
    idle();
    chk("len1_stop", 34'(bus.out_valid), 34'(0));
    // a=k+1j, b=2: products 2k+2j over k=1,2,3 with gaps
    bus.acc_len = 8'd3;
    drive(1'b1, 16'h0101, 16'h0101, 16'h0202, 16'h0, 1'b0);
    idle();
    idle();
    drive(1'b1, 16'h0202, 16'h0101, 16'h0202, 16'h0, 1'b0);
    idle();
    chk("gap_mid", 34'(bus.out_valid), 34'(0));
    drive(1'b1, 16'h0303, 16'h0101, 16'h0202, 16'h0, 1'b0);
    idle();
    chk("gap_early", 34'(bus.out_valid), 34'(0));
    idle();
    chk("gap_valid", 34'(bus.out_valid), 34'(1));
    chk("gap_re", bus.out_re, two(12, 12));
    chk("gap_im", bus.out_im, two(6, 6));
    bus.acc_len = 8'd4;
    drive(1'b1, 16'h0303, 16'h0404, 16'h0101, 16'h0202, 1'b0);
    drive(1'b1, 16'h0303, 16'h0404, 16'h0101, 16'h0202, 1'b0);
    bus.clr = 1'b1;
    drive(1'b1, 16'h0303, 16'h0404, 16'h0101, 16'h0202, 1'b0);
    bus.clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk($sformatf("clr_quiet%0d", i), 34'(bus.out_valid), 34'(0));
    end
    chk("clr_hold_re", bus.out_re, two(12, 12));
    for (int i = 0; i < 4; i++) drive(1'b1, 16'h0101, 16'h0, 16'h0101, 16'h0, 1'b0);
    idle();
    chk("clr_early", 34'(bus.out_valid), 34'(0));
    idle();
    chk("clr_valid", 34'(bus.out_valid), 34'(1));
    chk("clr_re", bus.out_re, two(4, 4));
    chk("clr_im", bus.out_im, 34'(0));
    drive(1'b1, 16'h0303, 16'h0404, 16'h0101, 16'h0202, 1'b0);
    drive(1'b1, 16'h0303, 16'h0404, 16'h0101, 16'h0202, 1'b0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("mrst_valid", 34'(bus.out_valid), 34'(0));
    chk("mrst_re", bus.out_re, 34'(0));
    chk("mrst_im", bus.out_im, 34'(0));
    chk("mrst_ovf", 34'(bus.ovf), 34'(0));
    for (int i = 0; i < 3; i++) idle();
    chk("mrst_quiet", 34'(bus.out_valid), 34'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
